fetch_slot_sched: RTL

//   Time-sliced round-robin scheduler sharing one fetch-queue port among N_REQ requesters.

---
 rtl/fetch_slot_sched_if.sv | 31 +++
 rtl/fetch_slot_sched.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_slot_sched_if.sv
// Bus between the fetch-slot scheduler and its requesters: request levels,
// stall and quantum in; registered one-hot grant and slot status out.
interface fetch_slot_sched_if #(
    parameter int N_REQ = 4,
    parameter int QW    = 8
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: req[i] is a level held while requester i has work; gnt[i]
    // names the owner for that cycle, and a granted cycle only counts toward
    // the quantum when stall is low (stall is the downstream not-ready).
    logic [N_REQ-1:0] req;
    logic             stall;
    logic [QW-1:0]    quantum;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic [QW-1:0]    slot_cnt;
    logic             slot_end;
    logic             preempt;

    modport master (
        output req, stall, quantum,
        input  gnt, gnt_vld, gnt_id, slot_cnt, slot_end, preempt
    );

    modport slave (
        input  req, stall, quantum,
        output gnt, gnt_vld, gnt_id, slot_cnt, slot_end, preempt
    );
endinterface

// File: rtl/fetch_slot_sched.sv
// Time-sliced round-robin scheduler for one shared fetch-queue port; each
// owner keeps the port for a latched quantum of unstalled cycles, then a gap.
module fetch_slot_sched #(
    parameter int N_REQ = 4,
    parameter int QW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    fetch_slot_sched_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] HANDOFF = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] gnt_r;
    logic [IDW-1:0]   gnt_id_r;
    logic [QW-1:0]    slot_cnt_r;
    logic [QW-1:0]    q_lat;

    logic             found;
    logic [IDW-1:0]   win;
    logic [N_REQ-1:0] win_onehot;
    logic             owner_req;
    logic             release_c;
    logic             expiry_c;
    logic [QW-1:0]    q_next;
    logic [IDW-1:0]   ptr_next;

    // Round-robin search starting at ptr; ptr already points past the last
    // owner by the time HANDOFF arbitrates.
    always_comb begin
        int idx;
        found      = 1'b0;
        win        = '0;
        win_onehot = '0;
        idx        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        win_onehot[win] = found;
    end

    always_comb begin
        owner_req = bus.req[gnt_id_r];
        release_c = (state == GRANT) && !owner_req;
        expiry_c  = (state == GRANT) && !bus.stall && (slot_cnt_r == q_lat - QW'(1));
        q_next    = (bus.quantum == '0) ? QW'(1) : bus.quantum;
        ptr_next  = (gnt_id_r == IDW'(N_REQ - 1)) ? '0 : gnt_id_r + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_r      <= '0;
            gnt_id_r   <= '0;
            slot_cnt_r <= '0;
            q_lat      <= '0;
        end else begin
            case (state)
                IDLE, HANDOFF: begin
                    if (found) begin
                        state      <= GRANT;
                        gnt_r      <= win_onehot;
                        gnt_id_r   <= win;
                        slot_cnt_r <= '0;
                        q_lat      <= q_next;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_c || expiry_c) begin
                        state      <= HANDOFF;
                        ptr        <= ptr_next;
                        gnt_r      <= '0;
                        gnt_id_r   <= '0;
                        slot_cnt_r <= '0;
                    end else if (!bus.stall) begin
                        slot_cnt_r <= slot_cnt_r + QW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt_r    <= '0;
                    gnt_id_r <= '0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.gnt_vld  = |gnt_r;
    assign bus.gnt_id   = gnt_id_r;
    assign bus.slot_cnt = slot_cnt_r;
    assign bus.slot_end = release_c || expiry_c;
    // A releasing owner is not pre-empted, even when its quantum also expires.
    assign bus.preempt  = expiry_c && owner_req;
    assign state_dbg    = state;

endmodule
